// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-uncache line port and decode handshake.
// The fetch queue connects through the master modport; the uncache/decode side uses slave.
interface inst_fetch_queue_if;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [127:0] inst_rdata;
  logic         out_valid;
  logic [31:0]  out_inst;
  logic [31:0]  out_pc;
  logic         out_ready;

  modport master (
    input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
    output inst_req, inst_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
    input  inst_req, inst_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch stage: requests 16-byte lines from the instruction uncache, splits them into words and
// queues them with their PCs for decode. A redirect flushes the queue and drops any in-flight line.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 8
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, next_state;

  logic [31:0] fetch_pc, req_pc;
  logic [AW:0] wr_ptr, rd_ptr, count, free;
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic        empty, accept, push_en, pop;
  logic [1:0]  push_start;
  logic [2:0]  push_cnt;

  assign count      = wr_ptr - rd_ptr;
  assign free       = (AW+1)'(DEPTH) - count;
  assign empty      = (wr_ptr == rd_ptr);
  assign accept     = (state == IDLE) & bus.inst_req & bus.inst_addr_ok;
  assign push_en    = (state == WAIT) & bus.inst_data_ok & ~bus.redirect_valid;
  assign push_start = req_pc[3:2];
  assign push_cnt   = 3'd4 - {1'b0, push_start};
  assign pop        = ~empty & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // A returning line always closes the outstanding request, so data_ok wins over a redirect
  // in WAIT/DROP; a redirect only turns an unanswered request into a drop.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.redirect_valid) begin
          if (bus.inst_addr_ok) next_state = DROP;
        end else if (accept) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.inst_data_ok)        next_state = IDLE;
        else if (bus.redirect_valid) next_state = DROP;
      end
      DROP: begin
        if (bus.inst_data_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.inst_req = 1'b0;
    if (state == IDLE) bus.inst_req = rst & ~bus.redirect_valid & (free >= (AW+1)'(4));
  end

  assign bus.inst_addr = {fetch_pc[31:4], 4'b0000};
  assign bus.out_valid = ~empty;
  assign bus.out_inst  = empty ? '0 : mem_inst[rd_ptr[AW-1:0]];
  assign bus.out_pc    = empty ? '0 : mem_pc[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (accept) begin
        req_pc   <= fetch_pc;
        fetch_pc <= {fetch_pc[31:4] + 28'd1, 4'b0000};
      end
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(push_cnt);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Leading words of a mid-line fetch are skipped: slot k holds line word push_start+k.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (3'(k) < push_cnt) begin
          mem_inst[wr_ptr[AW-1:0] + AW'(k)] <= bus.inst_rdata[32*(push_start + 2'(k)) +: 32];
          mem_pc[wr_ptr[AW-1:0] + AW'(k)]   <= {req_pc[31:4], push_start + 2'(k), 2'b00};
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a small uncache model answers line requests and a scoreboard
// holds the expected (pc, inst) stream, compared on every accepted decode handshake.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if bus();
  inst_fetch_queue #(.RESET_PC(32'hBFC0_0000), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  int unsigned uc_lines_left, uc_delay, uc_cnt, uc_lines_done;
  bit          uc_busy, uc_rand_delay, uc_granted, uc_fired, rand_ready, stray_data, word_mode, prev_req;
  logic [31:0] uc_line, uc_last_addr, prev_addr;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return word_mode ? (pc ^ 32'h5A5A_5A5A) : {30'd0, pc[3:2]};
  endfunction

  task automatic push_line(input logic [31:0] base, input int first);
    exp_t e;
    for (int i = first; i < 4; i++) begin
      e.pc   = {base[31:4], 2'(i), 2'b00};
      e.inst = word_of(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: entered and left at 1 time unit after the rising edge.
  task automatic cycle();
    exp_t e;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    uc_granted = 1'b0;
    uc_fired   = 1'b0;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    if (stray_data) begin
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = '1;
    end
    #1;
    if (!rst) begin
      uc_busy = 1'b0;
    end else if (uc_busy) begin
      if (uc_cnt == 0) begin
        bus.inst_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) bus.inst_rdata[32*i +: 32] = word_of({uc_line[31:4], 2'(i), 2'b00});
        uc_busy = 1'b0;
        uc_fired = 1'b1;
        uc_lines_done++;
      end else begin
        uc_cnt--;
      end
    end else if (bus.inst_req === 1'b1 && uc_lines_left > 0) begin
      bus.inst_addr_ok = 1'b1;
      uc_line = bus.inst_addr;
      uc_last_addr = bus.inst_addr;
      uc_busy = 1'b1;
      uc_granted = 1'b1;
      uc_lines_left--;
      uc_cnt = (uc_rand_delay ? $urandom_range(1, 5) : uc_delay) - 1;
    end
    if (prev_req && bus.inst_req === 1'b1 && rst) begin
      tests++;
      if (bus.inst_addr !== prev_addr) begin
        fails++;
        $display("FAIL req_hold: inst_addr changed to %h while request held at %h", bus.inst_addr, prev_addr);
      end
    end
    prev_req  = (bus.inst_req === 1'b1) && !bus.inst_addr_ok;
    prev_addr = bus.inst_addr;
    @(negedge clk);
    if (rst && !bus.redirect_valid && bus.out_valid === 1'b1 && bus.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: got pc=%h inst=%h, expected no output", bus.out_pc, bus.out_inst);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_inst !== e.inst) begin
          fails++;
          $display("FAIL scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h", bus.out_pc, bus.out_inst, e.pc, e.inst);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cycle();
    tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b, expected 0", bus.inst_req); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.out_inst !== 32'h0) begin fails++; $display("FAIL rst_inst: got %h, expected 0", bus.out_inst); end
    tests++; if (bus.out_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h, expected 0", bus.out_pc); end
    tests++; if (bus.inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL rst_addr: got %h, expected bfc00000", bus.inst_addr); end
  endtask

  task automatic test_first_line();
    word_mode = 1'b0; uc_lines_left = 1; uc_delay = 3; bus.out_ready = 1'b1;
    push_line(32'hBFC0_0000, 0);
    rst = 1'b1;
    #1;
    tests++; if (bus.inst_req !== 1'b1) begin fails++; $display("FAIL t1_first_req: got %b, expected 1", bus.inst_req); end
    tests++; if (bus.inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL t1_addr: got %h, expected bfc00000", bus.inst_addr); end
    cycle();
    tests++; if (bus.inst_addr !== 32'hBFC0_0010) begin fails++; $display("FAIL t1_next_addr: got %h, expected bfc00010", bus.inst_addr); end
    tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL t1_wait_req: got %b, expected 0", bus.inst_req); end
    for (int n = 0; n < 10 && !uc_fired; n++) cycle();
    tests++; if (!uc_fired) begin fails++; $display("FAIL t1_data_timeout: got no data_ok, expected one"); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL t1_valid_%0d: got %b, expected 1", k, bus.out_valid); end
      cycle();
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL t1_drained: got %b, expected 0", bus.out_valid); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL t1_left: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int unsigned d0;
    d0 = uc_lines_done;
    word_mode = 1'b1; bus.out_ready = 1'b0; uc_lines_left = 2; uc_delay = 2;
    push_line(32'hBFC0_0010, 0);
    push_line(32'hBFC0_0020, 0);
    repeat (20) cycle();
    tests++; if (uc_lines_done - d0 != 2) begin fails++; $display("FAIL t2_lines: got %0d, expected 2", uc_lines_done - d0); end
    tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL t2_full_req: got %b, expected 0", bus.inst_req); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL t2_full_valid: got %b, expected 1", bus.out_valid); end
    for (int k = 0; k < 3; k++) begin
      bus.out_ready = 1'b1; cycle(); bus.out_ready = 1'b0;
      tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL t2_pop%0d_req: got %b, expected 0", k, bus.inst_req); end
    end
    bus.out_ready = 1'b1; cycle(); bus.out_ready = 1'b0;
    tests++; if (bus.inst_req !== 1'b1) begin fails++; $display("FAIL t2_pop3_req: got %b, expected 1", bus.inst_req); end
    tests++; if (bus.inst_addr !== 32'hBFC0_0030) begin fails++; $display("FAIL t2_addr: got %h, expected bfc00030", bus.inst_addr); end
  endtask

  task automatic test_midline_redirect();
    exp_q.delete();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_100B;
    #1;
    tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL t3_req_forced: got %b, expected 0", bus.inst_req); end
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL t3_flush: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.inst_req !== 1'b1) begin fails++; $display("FAIL t3_req: got %b, expected 1", bus.inst_req); end
    tests++; if (bus.inst_addr !== 32'h8000_1000) begin fails++; $display("FAIL t3_addr: got %h, expected 80001000", bus.inst_addr); end
    push_line(32'h8000_1000, 2);
    bus.out_ready = 1'b1; uc_lines_left = 1; uc_delay = 2;
    for (int n = 0; n < 50 && exp_q.size() > 0; n++) cycle();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL t3_drain: got %0d left, expected 0", exp_q.size()); end
    tests++; if (bus.inst_addr !== 32'h8000_1010) begin fails++; $display("FAIL t3_next_addr: got %h, expected 80001010", bus.inst_addr); end
  endtask

  task automatic test_redirect_in_wait();
    uc_lines_left = 1; uc_delay = 4;
    cycle();
    tests++; if (!uc_granted) begin fails++; $display("FAIL t4_grant: got no addr_ok, expected one"); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_2000;
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL t4_drop_req: got %b, expected 0", bus.inst_req); end
    tests++; if (bus.inst_addr !== 32'h8000_2000) begin fails++; $display("FAIL t4_addr: got %h, expected 80002000", bus.inst_addr); end
    push_line(32'h8000_2000, 0);
    uc_lines_left = 1; uc_delay = 2;
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) cycle();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL t4_drain: got %0d left, expected 0", exp_q.size()); end
    tests++; if (uc_last_addr !== 32'h8000_2000) begin fails++; $display("FAIL t4_req_addr: got %h, expected 80002000", uc_last_addr); end
  endtask

  task automatic test_redirect_collision();
    int unsigned d0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_2008;
    cycle();
    bus.redirect_valid = 1'b0;
    push_line(32'h8000_2000, 2);
    uc_lines_left = 1; uc_delay = 2;
    d0 = uc_lines_done;
    for (int n = 0; n < 20 && uc_lines_done == d0; n++) cycle();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL t5_queued: got %b, expected 1", bus.out_valid); end
    uc_lines_left = 1; uc_delay = 3;
    cycle();
    tests++; if (!uc_granted) begin fails++; $display("FAIL t5_grant: got no addr_ok, expected one"); end
    cycle();
    cycle();
    exp_q.delete();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_3004; bus.out_ready = 1'b1;
    cycle();
    tests++; if (!uc_fired) begin fails++; $display("FAIL t5_same_cycle: got no data_ok with redirect, expected one"); end
    bus.redirect_valid = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL t5_valid: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.inst_req !== 1'b1) begin fails++; $display("FAIL t5_idle_req: got %b, expected 1", bus.inst_req); end
    tests++; if (bus.inst_addr !== 32'h8000_3000) begin fails++; $display("FAIL t5_addr: got %h, expected 80003000", bus.inst_addr); end
    push_line(32'h8000_3000, 1);
    uc_lines_left = 1; uc_delay = 1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) cycle();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL t5_drain: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_stream();
    int unsigned d0;
    d0 = uc_lines_done;
    for (int l = 0; l < 6; l++) push_line(32'h8000_3010 + 32'(l * 16), 0);
    uc_lines_left = 6; uc_rand_delay = 1'b1; rand_ready = 1'b1;
    for (int n = 0; n < 2000 && exp_q.size() > 0; n++) cycle();
    rand_ready = 1'b0; uc_rand_delay = 1'b0; bus.out_ready = 1'b1;
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL t6_drain: got %0d left, expected 0", exp_q.size()); end
    repeat (3) cycle();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL t6_extra: got %b, expected 0", bus.out_valid); end
    tests++; if (uc_lines_done - d0 != 6) begin fails++; $display("FAIL t6_lines: got %0d, expected 6", uc_lines_done - d0); end
  endtask

  task automatic test_stray_data();
    stray_data = 1'b1;
    cycle();
    stray_data = 1'b0;
    repeat (2) cycle();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stray_valid: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.inst_addr !== 32'h8000_3070) begin fails++; $display("FAIL stray_addr: got %h, expected 80003070", bus.inst_addr); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0; uc_lines_left = 1; uc_delay = 1;
    for (int n = 0; n < 20 && bus.out_valid !== 1'b1; n++) cycle();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mr_fill: got %b, expected 1", bus.out_valid); end
    rst = 1'b0;
    exp_q.delete();
    cycle();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mr_valid: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.out_pc !== 32'h0) begin fails++; $display("FAIL mr_pc: got %h, expected 0", bus.out_pc); end
    tests++; if (bus.out_inst !== 32'h0) begin fails++; $display("FAIL mr_inst: got %h, expected 0", bus.out_inst); end
    tests++; if (bus.inst_req !== 1'b0) begin fails++; $display("FAIL mr_req: got %b, expected 0", bus.inst_req); end
    tests++; if (bus.inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL mr_addr: got %h, expected bfc00000", bus.inst_addr); end
    rst = 1'b1;
    #1;
    tests++; if (bus.inst_req !== 1'b1) begin fails++; $display("FAIL mr_req_after: got %b, expected 1", bus.inst_req); end
  endtask

  initial begin
    rst = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0; bus.out_ready = 1'b0;
    uc_lines_left = 0; uc_delay = 1; uc_cnt = 0; uc_lines_done = 0;
    uc_busy = 1'b0; uc_rand_delay = 1'b0; uc_granted = 1'b0; uc_fired = 1'b0;
    rand_ready = 1'b0; stray_data = 1'b0; word_mode = 1'b0; prev_req = 1'b0;
    uc_line = '0; uc_last_addr = '0; prev_addr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_first_line();
    test_backpressure();
    test_midline_redirect();
    test_redirect_in_wait();
    test_redirect_collision();
    test_stream();
    test_stray_data();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
